// File: rtl/x_ramd16_fifo.sv
// x_ramd16_fifo: 16-entry FIFO built on a dual-port RAM (synchronous write,
// asynchronous read) with a registered output stage in front of the consumer.
//
// Ports:
//   clk       rising-edge clock
//   rstn      synchronous active-low reset
//   wr_en     write request; accepted when full is low
//   wr_data   write data, sampled with wr_en
//   full      RAM holds 16 entries (registered)
//   rd_data   head-of-queue data from the output register
//   rd_valid  rd_data holds a valid entry
//   rd_ready  consumer accepts rd_data when rd_valid is high
//   empty     RAM holds no entries and rd_valid is low (registered)
//   count     total entries held, RAM plus output register (0..17)
//   overflow  sticky: a write was attempted while full
//
// Total capacity is 17: 16 in the RAM plus one in the output register.
module x_ramd16_fifo #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             empty,
    output logic [4:0]       count,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [16];

    logic [3:0]       wptr_q, rptr_q;
    logic [4:0]       ram_cnt_q, ram_cnt_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             overflow_q, overflow_d;

    logic accept;
    logic load;
    logic pop;

    assign accept = wr_en & ~full_q;
    // Load uses the RAM count before this edge's write, so a write never
    // bypasses straight into the output register.
    assign load   = (~rd_valid_q | rd_ready) & (ram_cnt_q != 5'd0);
    assign pop    = rd_valid_q & rd_ready;

    always_comb begin
        ram_cnt_d = ram_cnt_q;
        if (accept && !load) begin
            ram_cnt_d = ram_cnt_q + 5'd1;
        end else if (load && !accept) begin
            ram_cnt_d = ram_cnt_q - 5'd1;
        end

        rd_valid_d = rd_valid_q;
        if (load) begin
            rd_valid_d = 1'b1;
        end else if (pop) begin
            rd_valid_d = 1'b0;
        end

        full_d     = (ram_cnt_d == 5'd16);
        empty_d    = (ram_cnt_d == 5'd0) && !rd_valid_d;
        overflow_d = overflow_q | (wr_en & full_q);
    end

    // RAM contents are deliberately not reset; stale entries are unreachable
    // because the pointers restart at zero.
    always_ff @(posedge clk) begin
        if (rstn && accept) begin
            mem[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q     <= 4'd0;
            rptr_q     <= 4'd0;
            ram_cnt_q  <= 5'd0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= INIT;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                wptr_q <= wptr_q + 4'd1;
            end
            if (load) begin
                rptr_q    <= rptr_q + 4'd1;
                rd_data_q <= mem[rptr_q];
            end
            ram_cnt_q  <= ram_cnt_d;
            rd_valid_q <= rd_valid_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign overflow = overflow_q;
    assign count    = ram_cnt_q + {4'd0, rd_valid_q};

endmodule

// File: doc/x_ramd16_fifo.md
X_RAMD16_FIFO -- requirements
Module: x_ramd16_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; legal range 1..32.
REQ-002 Parameter INIT, default 0, value loaded into RD_DATA at reset.
REQ-003 CLK  input  1  clock; all state changes on the rising edge.
REQ-004 RSTN  input  1  reset; synchronous and active-low.
REQ-005 WR_EN  input  1  write request, sampled each rising edge.
REQ-006 WR_DATA  input  WIDTH  write data, sampled with WR_EN.
REQ-007 FULL  output  1  high when the storage RAM holds 16 entries.
REQ-008 RD_DATA  output  WIDTH  head-of-queue data from the output register.
REQ-009 RD_VALID  output  1  RD_DATA holds a valid entry.
REQ-010 RD_READY  input  1  consumer accepts RD_DATA when RD_VALID is also high.
REQ-011 EMPTY  output  1  high when the RAM holds 0 entries and RD_VALID is low.
REQ-012 COUNT  output  5  total entries held (RAM plus output register), range 0..17.
REQ-013 OVERFLOW  output  1  sticky flag for a write attempt while FULL.

Function
REQ-014 Storage SHALL be a 16 x WIDTH dual-port RAM: synchronous write, asynchronous read, 4-bit write pointer WPTR, 4-bit read pointer RPTR.
REQ-015 Write accept = WR_EN & !FULL; on accept, mem[WPTR] <= WR_DATA and WPTR increments mod 16 (15 -> 0).
REQ-016 WR_EN while FULL SHALL be dropped: no memory, pointer or count change, and OVERFLOW <= 1.
REQ-017 OVERFLOW SHALL stay high until reset.
REQ-018 Output-register load = (!RD_VALID | RD_READY) & (RAM count != 0), with RAM count taken before this edge's write.
REQ-019 On load: RD_DATA <= mem[RPTR], RPTR increments mod 16, RD_VALID <= 1.
REQ-020 Pop = RD_VALID & RD_READY; pop with no load SHALL clear RD_VALID and leave RD_DATA unchanged.
REQ-021 RD_DATA SHALL stay stable while RD_VALID & !RD_READY.
REQ-022 Latency: a write accepted at edge E into an empty FIFO SHALL give RD_VALID=1 after edge E+1. No write-to-read bypass.
REQ-023 RAM count SHALL be +1 on accept only, -1 on load only, and unchanged on accept plus load in the same cycle.
REQ-024 FULL and EMPTY SHALL be registered, consistent with COUNT after every edge, and never high together.
REQ-025 COUNT SHALL equal RAM count + RD_VALID.
REQ-026 Simultaneous accept and load with WPTR == RPTR SHALL not occur, because the RAM is then either empty (no load) or full (no accept).
REQ-027 RD_READY while RD_VALID=0 SHALL have no effect (no underflow, no pointer motion).
REQ-028 Full throughput: with RD_READY held high and one write per cycle, the FIFO SHALL sustain one entry per cycle and COUNT SHALL stay at 1 or 2.

Reset
REQ-029 RSTN=0 at a rising edge SHALL set WPTR=0, RPTR=0, RAM count=0, RD_VALID=0, RD_DATA=INIT, OVERFLOW=0, FULL=0, EMPTY=1, COUNT=0.
REQ-030 Reset SHALL override WR_EN and RD_READY in the same cycle; an in-flight write or pop is discarded.
REQ-031 RAM contents SHALL NOT be cleared by reset; entries are unreachable until rewritten.
REQ-032 Reset asserted mid-operation (any COUNT) SHALL give the REQ-029 state after that single edge.

Verification
REQ-033 Reset, then write 0x11 at edge 1 with RD_READY=0 -> RD_VALID=1 and RD_DATA=0x11 after edge 2; COUNT=1; EMPTY=0.
REQ-034 With RD_READY=0, write 0x00..0x10 (17 writes) -> FULL=1 after the 17th accept, COUNT=17, RD_DATA=0x00; an 18th write -> OVERFLOW=1, COUNT stays 17.
REQ-035 From the REQ-034 state, hold RD_READY=1 and write nothing -> RD_DATA steps 0x01..0x10 one per cycle; then RD_VALID=0, EMPTY=1, COUNT=0, OVERFLOW still 1.
REQ-036 Stream 40 writes with RD_READY=1 -> all 40 values pop in order with no gaps after the first (covers pointer wrap 15->0 at least twice); COUNT never above 2.
REQ-037 Hold RD_VALID=1 with RD_READY=0 for 5 cycles while writing 3 entries -> RD_DATA unchanged, COUNT rises by 3.
REQ-038 Drive RSTN=0 for one edge with COUNT=9 and OVERFLOW=1 -> all REQ-029 values; a following write of 0x5A reads back 0x5A (not stale data) after 2 edges.
